// File: rtl/axi_mst_arbiter_pkg.sv
// Shared types and AXI constants for the IFU/LSU AXI master arbiter.
package axi_mst_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_AR   = 3'd1,
        ST_RD_R    = 3'd2,
        ST_WR_AW_W = 3'd3,
        ST_WR_B    = 3'd4
    } arb_state_e;

    localparam int ID_W = 4;

    localparam logic [1:0]      AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0]      AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0]      AXI_RESP_SLVERR = 2'b10;
    localparam logic [ID_W-1:0] AXI_ID_IFU      = 4'd0;
    localparam logic [ID_W-1:0] AXI_ID_LSU      = 4'd1;
    localparam logic [2:0]      AXI_SIZE_WORD   = 3'b010;

    // Bits needed to hold a counter value of 0..limit.
    function automatic int cnt_width(input int limit);
        int w;
        w = 1;
        while ((1 << w) <= limit) w++;
        return w;
    endfunction

endpackage

// File: rtl/axi_mst_arbiter_if.sv
// Bundle of requester-side (IFU/LSU) and AXI4 master-side signals around the arbiter.
interface axi_mst_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import axi_mst_arbiter_pkg::*;
    localparam int STRB_W = DATA_W / 8;

    logic              ifu_ar_valid, ifu_ar_ready;
    logic [ADDR_W-1:0] ifu_ar_addr;
    logic              ifu_r_valid, ifu_r_ready;
    logic [DATA_W-1:0] ifu_r_data;
    logic [1:0]        ifu_r_resp;

    logic              lsu_ar_valid, lsu_ar_ready;
    logic [ADDR_W-1:0] lsu_ar_addr;
    logic [2:0]        lsu_ar_size;
    logic              lsu_r_valid, lsu_r_ready;
    logic [DATA_W-1:0] lsu_r_data;
    logic [1:0]        lsu_r_resp;
    logic              lsu_aw_valid, lsu_aw_ready;
    logic [ADDR_W-1:0] lsu_aw_addr;
    logic [2:0]        lsu_aw_size;
    logic              lsu_w_valid, lsu_w_ready;
    logic [DATA_W-1:0] lsu_w_data;
    logic [STRB_W-1:0] lsu_w_strb;
    logic              lsu_b_valid, lsu_b_ready;
    logic [1:0]        lsu_b_resp;

    logic              mst_arvalid, mst_arready;
    logic [ADDR_W-1:0] mst_araddr;
    logic [ID_W-1:0]   mst_arid;
    logic [7:0]        mst_arlen;
    logic [2:0]        mst_arsize;
    logic [1:0]        mst_arburst;
    logic              mst_rvalid, mst_rready, mst_rlast;
    logic [DATA_W-1:0] mst_rdata;
    logic [1:0]        mst_rresp;
    logic [ID_W-1:0]   mst_rid;
    logic              mst_awvalid, mst_awready;
    logic [ADDR_W-1:0] mst_awaddr;
    logic [ID_W-1:0]   mst_awid;
    logic [7:0]        mst_awlen;
    logic [2:0]        mst_awsize;
    logic [1:0]        mst_awburst;
    logic              mst_wvalid, mst_wready, mst_wlast;
    logic [DATA_W-1:0] mst_wdata;
    logic [STRB_W-1:0] mst_wstrb;
    logic              mst_bvalid, mst_bready;
    logic [1:0]        mst_bresp;
    logic [ID_W-1:0]   mst_bid;

    logic              dbg_rid_err;

    // Arbiter view: it is the AXI master and the responder to IFU/LSU.
    modport master (
        input  ifu_ar_valid, ifu_ar_addr, ifu_r_ready,
        output ifu_ar_ready, ifu_r_valid, ifu_r_data, ifu_r_resp,
        input  lsu_ar_valid, lsu_ar_addr, lsu_ar_size, lsu_r_ready,
        input  lsu_aw_valid, lsu_aw_addr, lsu_aw_size,
        input  lsu_w_valid, lsu_w_data, lsu_w_strb, lsu_b_ready,
        output lsu_ar_ready, lsu_r_valid, lsu_r_data, lsu_r_resp,
        output lsu_aw_ready, lsu_w_ready, lsu_b_valid, lsu_b_resp,
        output mst_arvalid, mst_araddr, mst_arid, mst_arlen, mst_arsize, mst_arburst,
        input  mst_arready,
        input  mst_rvalid, mst_rdata, mst_rresp, mst_rlast, mst_rid,
        output mst_rready,
        output mst_awvalid, mst_awaddr, mst_awid, mst_awlen, mst_awsize, mst_awburst,
        input  mst_awready,
        output mst_wvalid, mst_wdata, mst_wstrb, mst_wlast,
        input  mst_wready,
        input  mst_bvalid, mst_bresp, mst_bid,
        output mst_bready,
        output dbg_rid_err
    );

    // Environment view: requesters plus the downstream AXI slave.
    modport slave (
        output ifu_ar_valid, ifu_ar_addr, ifu_r_ready,
        input  ifu_ar_ready, ifu_r_valid, ifu_r_data, ifu_r_resp,
        output lsu_ar_valid, lsu_ar_addr, lsu_ar_size, lsu_r_ready,
        output lsu_aw_valid, lsu_aw_addr, lsu_aw_size,
        output lsu_w_valid, lsu_w_data, lsu_w_strb, lsu_b_ready,
        input  lsu_ar_ready, lsu_r_valid, lsu_r_data, lsu_r_resp,
        input  lsu_aw_ready, lsu_w_ready, lsu_b_valid, lsu_b_resp,
        input  mst_arvalid, mst_araddr, mst_arid, mst_arlen, mst_arsize, mst_arburst,
        output mst_arready,
        output mst_rvalid, mst_rdata, mst_rresp, mst_rlast, mst_rid,
        input  mst_rready,
        input  mst_awvalid, mst_awaddr, mst_awid, mst_awlen, mst_awsize, mst_awburst,
        output mst_awready,
        input  mst_wvalid, mst_wdata, mst_wstrb, mst_wlast,
        output mst_wready,
        output mst_bvalid, mst_bresp, mst_bid,
        input  mst_bready,
        input  dbg_rid_err
    );

endinterface

// File: rtl/axi_mst_arbiter_rr_arb2.sv
// Two-requester round-robin picker; pointer moves to the losing side after each grant.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant
);
    logic r_ptr;

    // A requester wins when alone, or on a tie when the pointer favours it.
    for (genvar gi = 0; gi < 2; gi++) begin : g_grant
        assign o_grant[gi] = i_req[gi] & (~i_req[1-gi] | (r_ptr == 1'(gi)));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_ptr <= 1'b0;
        end else if (i_advance) begin
            r_ptr <= o_grant[0];
        end
    end

endmodule

// File: rtl/axi_mst_arbiter.sv
// Shares one single-beat AXI4 master port between IFU fetch and LSU load/store.
// Optional response watchdog: define YSYX_23060251_ARB_TIMEOUT_EN.
module axi_mst_arbiter
    import axi_mst_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    axi_mst_arbiter_if.master io_bus
);
    localparam int STRB_W = DATA_W / 8;

    arb_state_e        r_state, w_state_next;
    logic              r_gnt_lsu;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_size;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              r_arvalid, r_awvalid, r_wvalid, r_rid_err;

    logic       w_lsu_wr, w_lsu_req, w_can_grant, w_accept;
    logic [1:0] w_req, w_grant;
    logic       w_rsp_ready, w_timeout, w_drain, w_id_bad;
    logic [ID_W-1:0] w_exp_id;

    assign w_lsu_wr    = io_bus.lsu_aw_valid & io_bus.lsu_w_valid;
    assign w_lsu_req   = w_lsu_wr | io_bus.lsu_ar_valid;
    assign w_can_grant = (r_state == ST_IDLE) & ~w_drain & rst_i;
    assign w_req       = {w_lsu_req, io_bus.ifu_ar_valid} & {2{w_can_grant}};
    assign w_accept    = |w_grant;
    assign w_rsp_ready = r_gnt_lsu ? io_bus.lsu_r_ready : io_bus.ifu_r_ready;
    assign w_exp_id    = r_gnt_lsu ? AXI_ID_LSU : AXI_ID_IFU;

    rr_arb2 u_rr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_req     (w_req),
        .i_advance (w_accept),
        .o_grant   (w_grant)
    );

`ifdef YSYX_23060251_ARB_TIMEOUT_EN
    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] r_to_cnt;
    logic             r_drain;

    assign w_timeout = ((r_state == ST_RD_R) || (r_state == ST_WR_B)) &&
                       (r_to_cnt == CNT_W'(TIMEOUT_CYCLES));
    assign w_drain   = r_drain;

    // Drain swallows the late response of an abandoned transaction before any new grant.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_to_cnt <= '0;
            r_drain  <= 1'b0;
        end else begin
            if (w_state_next == ST_IDLE) begin
                r_to_cnt <= '0;
            end else if (((r_state == ST_RD_R) || (r_state == ST_WR_B)) && !w_timeout) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_timeout && (w_state_next == ST_IDLE)) begin
                r_drain <= 1'b1;
            end else if (r_drain && (io_bus.mst_rvalid || io_bus.mst_bvalid)) begin
                r_drain <= 1'b0;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_drain   = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next         = r_state;
        io_bus.ifu_ar_ready  = 1'b0;
        io_bus.lsu_ar_ready  = 1'b0;
        io_bus.lsu_aw_ready  = 1'b0;
        io_bus.lsu_w_ready   = 1'b0;
        io_bus.ifu_r_valid   = 1'b0;
        io_bus.ifu_r_data    = io_bus.mst_rdata;
        io_bus.ifu_r_resp    = io_bus.mst_rresp;
        io_bus.lsu_r_valid   = 1'b0;
        io_bus.lsu_r_data    = io_bus.mst_rdata;
        io_bus.lsu_r_resp    = io_bus.mst_rresp;
        io_bus.lsu_b_valid   = 1'b0;
        io_bus.lsu_b_resp    = io_bus.mst_bresp;
        io_bus.mst_rready    = 1'b0;
        io_bus.mst_bready    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_drain) begin
                    io_bus.mst_rready = 1'b1;
                    io_bus.mst_bready = 1'b1;
                end else if (w_grant[0]) begin
                    io_bus.ifu_ar_ready = 1'b1;
                    w_state_next        = ST_RD_AR;
                end else if (w_grant[1]) begin
                    if (w_lsu_wr) begin
                        io_bus.lsu_aw_ready = 1'b1;
                        io_bus.lsu_w_ready  = 1'b1;
                        w_state_next        = ST_WR_AW_W;
                    end else begin
                        io_bus.lsu_ar_ready = 1'b1;
                        w_state_next        = ST_RD_AR;
                    end
                end
            end
            ST_RD_AR: begin
                if (io_bus.mst_arready) w_state_next = ST_RD_R;
            end
            ST_RD_R: begin
                if (w_timeout) begin
                    io_bus.ifu_r_valid = ~r_gnt_lsu;
                    io_bus.lsu_r_valid = r_gnt_lsu;
                    io_bus.ifu_r_data  = '0;
                    io_bus.lsu_r_data  = '0;
                    io_bus.ifu_r_resp  = AXI_RESP_SLVERR;
                    io_bus.lsu_r_resp  = AXI_RESP_SLVERR;
                    if (w_rsp_ready) w_state_next = ST_IDLE;
                end else begin
                    io_bus.mst_rready  = w_rsp_ready;
                    io_bus.ifu_r_valid = io_bus.mst_rvalid & ~r_gnt_lsu;
                    io_bus.lsu_r_valid = io_bus.mst_rvalid & r_gnt_lsu;
                    if (io_bus.mst_rvalid && w_rsp_ready && io_bus.mst_rlast) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_WR_AW_W: begin
                if ((!r_awvalid || io_bus.mst_awready) && (!r_wvalid || io_bus.mst_wready)) begin
                    w_state_next = ST_WR_B;
                end
            end
            ST_WR_B: begin
                if (w_timeout) begin
                    io_bus.lsu_b_valid = 1'b1;
                    io_bus.lsu_b_resp  = AXI_RESP_SLVERR;
                    if (io_bus.lsu_b_ready) w_state_next = ST_IDLE;
                end else begin
                    io_bus.mst_bready  = io_bus.lsu_b_ready;
                    io_bus.lsu_b_valid = io_bus.mst_bvalid;
                    if (io_bus.mst_bvalid && io_bus.lsu_b_ready) w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // A response carrying the wrong ID is still delivered; only the sticky flag records it.
    assign w_id_bad = !w_timeout &&
                      (((r_state == ST_RD_R) && io_bus.mst_rvalid && w_rsp_ready &&
                        (io_bus.mst_rid != w_exp_id)) ||
                       ((r_state == ST_WR_B) && io_bus.mst_bvalid && io_bus.lsu_b_ready &&
                        (io_bus.mst_bid != AXI_ID_LSU)));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_gnt_lsu <= 1'b0;
            r_addr    <= '0;
            r_size    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_arvalid <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_rid_err <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_grant[0]) begin
                    r_gnt_lsu <= 1'b0;
                    r_addr    <= io_bus.ifu_ar_addr;
                    r_size    <= AXI_SIZE_WORD;
                    r_arvalid <= 1'b1;
                end else if (w_lsu_wr) begin
                    r_gnt_lsu <= 1'b1;
                    r_addr    <= io_bus.lsu_aw_addr;
                    r_size    <= io_bus.lsu_aw_size;
                    r_wdata   <= io_bus.lsu_w_data;
                    r_wstrb   <= io_bus.lsu_w_strb;
                    r_awvalid <= 1'b1;
                    r_wvalid  <= 1'b1;
                end else begin
                    r_gnt_lsu <= 1'b1;
                    r_addr    <= io_bus.lsu_ar_addr;
                    r_size    <= io_bus.lsu_ar_size;
                    r_arvalid <= 1'b1;
                end
            end
            if (r_arvalid && io_bus.mst_arready) r_arvalid <= 1'b0;
            if (r_awvalid && io_bus.mst_awready) r_awvalid <= 1'b0;
            if (r_wvalid && io_bus.mst_wready)   r_wvalid  <= 1'b0;
            if (w_id_bad) r_rid_err <= 1'b1;
        end
    end

    assign io_bus.mst_arvalid = r_arvalid;
    assign io_bus.mst_araddr  = r_addr;
    assign io_bus.mst_arid    = w_exp_id;
    assign io_bus.mst_arlen   = 8'd0;
    assign io_bus.mst_arsize  = r_size;
    assign io_bus.mst_arburst = AXI_BURST_INCR;
    assign io_bus.mst_awvalid = r_awvalid;
    assign io_bus.mst_awaddr  = r_addr;
    assign io_bus.mst_awid    = AXI_ID_LSU;
    assign io_bus.mst_awlen   = 8'd0;
    assign io_bus.mst_awsize  = r_size;
    assign io_bus.mst_awburst = AXI_BURST_INCR;
    assign io_bus.mst_wvalid  = r_wvalid;
    assign io_bus.mst_wdata   = r_wdata;
    assign io_bus.mst_wstrb   = r_wstrb;
    assign io_bus.mst_wlast   = 1'b1;
    assign io_bus.dbg_rid_err = r_rid_err;

endmodule

// File: tb/tb_axi_mst_arbiter.sv
// Directed bench for axi_mst_arbiter; covers YSYX_23060251_ARB_TIMEOUT_EN when defined.
module tb_axi_mst_arbiter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    axi_mst_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_mst_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(255)) dut (
        .clk_i  (clk),
        .rst_i  (rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expect a registered AR beat, then let the slave accept it.
    task automatic ar_phase(input string tag, input logic [3:0] id, input logic [31:0] addr,
                            input logic [2:0] size);
        chk({tag, "_arvalid"}, bus.mst_arvalid, 1);
        chk({tag, "_araddr"},  bus.mst_araddr, addr);
        chk({tag, "_arid"},    bus.mst_arid, id);
        chk({tag, "_arlen"},   bus.mst_arlen, 0);
        chk({tag, "_arsize"},  bus.mst_arsize, size);
        chk({tag, "_arburst"}, bus.mst_arburst, 2'b01);
        bus.mst_arready = 1'b1;
        tick();
        bus.mst_arready = 1'b0;
        chk({tag, "_arvalid_drop"}, bus.mst_arvalid, 0);
    endtask

    task automatic r_phase(input string tag, input bit to_lsu, input logic [3:0] id,
                           input logic [31:0] data);
        bus.mst_rvalid = 1'b1;
        bus.mst_rdata  = data;
        bus.mst_rid    = id;
        bus.mst_rresp  = 2'b00;
        bus.mst_rlast  = 1'b1;
        #1;
        if (to_lsu) begin
            chk({tag, "_lsu_rvalid"}, bus.lsu_r_valid, 1);
            chk({tag, "_lsu_rdata"},  bus.lsu_r_data, data);
            chk({tag, "_lsu_rresp"},  bus.lsu_r_resp, 2'b00);
            chk({tag, "_ifu_rvalid"}, bus.ifu_r_valid, 0);
        end else begin
            chk({tag, "_ifu_rvalid"}, bus.ifu_r_valid, 1);
            chk({tag, "_ifu_rdata"},  bus.ifu_r_data, data);
            chk({tag, "_ifu_rresp"},  bus.ifu_r_resp, 2'b00);
            chk({tag, "_lsu_rvalid"}, bus.lsu_r_valid, 0);
        end
        chk({tag, "_rready"}, bus.mst_rready, 1);
        tick();
        bus.mst_rvalid = 1'b0;
        bus.mst_rlast  = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        bus.ifu_ar_valid = 1'b0; bus.ifu_ar_addr = '0; bus.ifu_r_ready = 1'b1;
        bus.lsu_ar_valid = 1'b0; bus.lsu_ar_addr = '0; bus.lsu_ar_size = '0; bus.lsu_r_ready = 1'b1;
        bus.lsu_aw_valid = 1'b0; bus.lsu_aw_addr = '0; bus.lsu_aw_size = '0;
        bus.lsu_w_valid  = 1'b0; bus.lsu_w_data  = '0; bus.lsu_w_strb  = '0; bus.lsu_b_ready = 1'b1;
        bus.mst_arready = 1'b0; bus.mst_awready = 1'b0; bus.mst_wready = 1'b0;
        bus.mst_rvalid = 1'b0; bus.mst_rdata = '0; bus.mst_rresp = '0; bus.mst_rlast = 1'b0; bus.mst_rid = '0;
        bus.mst_bvalid = 1'b0; bus.mst_bresp = '0; bus.mst_bid = '0;

        // Reset with an IFU request already pending: nothing may be accepted.
        bus.ifu_ar_valid = 1'b1;
        bus.ifu_ar_addr  = 32'h8000_0000;
        repeat (3) tick();
        chk("rst_ifu_ar_ready", bus.ifu_ar_ready, 0);
        chk("rst_arvalid", bus.mst_arvalid, 0);
        chk("rst_awvalid", bus.mst_awvalid, 0);
        chk("rst_wvalid", bus.mst_wvalid, 0);
        chk("rst_rready", bus.mst_rready, 0);
        chk("rst_bready", bus.mst_bready, 0);
        chk("rst_rid_err", bus.dbg_rid_err, 0);

        // Single IFU fetch, slave answers three cycles after AR.
        rst_n = 1'b1;
        #1;
        chk("ifu_ar_ready", bus.ifu_ar_ready, 1);
        tick();
        bus.ifu_ar_valid = 1'b0;
        ar_phase("ifu", 4'd0, 32'h8000_0000, 3'b010);
        repeat (3) tick();
        chk("ifu_r_wait", bus.ifu_r_valid, 0);
        r_phase("ifu", 1'b0, 4'd0, 32'h0000_0413);

        // Fresh reset, then simultaneous requests: IFU, LSU, IFU.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.ifu_ar_valid = 1'b1; bus.ifu_ar_addr = 32'h8000_0004;
        bus.lsu_ar_valid = 1'b1; bus.lsu_ar_addr = 32'h8000_0200; bus.lsu_ar_size = 3'b000;
        #1;
        chk("tie1_ifu_ready", bus.ifu_ar_ready, 1);
        chk("tie1_lsu_ready", bus.lsu_ar_ready, 0);
        tick();
        bus.ifu_ar_valid = 1'b0;
        ar_phase("tie1", 4'd0, 32'h8000_0004, 3'b010);
        r_phase("tie1", 1'b0, 4'd0, 32'h0000_0093);
        bus.ifu_ar_valid = 1'b1; bus.ifu_ar_addr = 32'h8000_0008;
        #1;
        chk("tie2_lsu_ready", bus.lsu_ar_ready, 1);
        chk("tie2_ifu_ready", bus.ifu_ar_ready, 0);
        tick();
        bus.lsu_ar_valid = 1'b0;
        ar_phase("tie2", 4'd1, 32'h8000_0200, 3'b000);
        r_phase("tie2", 1'b1, 4'd1, 32'h0000_00AB);
        chk("tie3_ifu_ready", bus.ifu_ar_ready, 1);
        tick();
        bus.ifu_ar_valid = 1'b0;
        ar_phase("tie3", 4'd0, 32'h8000_0008, 3'b010);
        r_phase("tie3", 1'b0, 4'd0, 32'h0000_0013);

        // LSU store alongside a pending LSU load: write wins; AW accepted two cycles before W.
        bus.lsu_aw_valid = 1'b1; bus.lsu_aw_addr = 32'h8000_0100; bus.lsu_aw_size = 3'b010;
        bus.lsu_w_valid  = 1'b1; bus.lsu_w_data  = 32'hDEAD_BEEF; bus.lsu_w_strb  = 4'hF;
        bus.lsu_ar_valid = 1'b1; bus.lsu_ar_addr = 32'h8000_0300; bus.lsu_ar_size = 3'b010;
        #1;
        chk("wr_aw_ready", bus.lsu_aw_ready, 1);
        chk("wr_w_ready", bus.lsu_w_ready, 1);
        chk("wr_ar_ready", bus.lsu_ar_ready, 0);
        tick();
        bus.lsu_aw_valid = 1'b0;
        bus.lsu_w_valid  = 1'b0;
        chk("wr_awvalid", bus.mst_awvalid, 1);
        chk("wr_awaddr", bus.mst_awaddr, 32'h8000_0100);
        chk("wr_awid", bus.mst_awid, 4'd1);
        chk("wr_awlen", bus.mst_awlen, 0);
        chk("wr_awsize", bus.mst_awsize, 3'b010);
        chk("wr_awburst", bus.mst_awburst, 2'b01);
        chk("wr_wvalid", bus.mst_wvalid, 1);
        chk("wr_wdata", bus.mst_wdata, 32'hDEAD_BEEF);
        chk("wr_wstrb", bus.mst_wstrb, 4'hF);
        chk("wr_wlast", bus.mst_wlast, 1);
        chk("wr_no_arvalid", bus.mst_arvalid, 0);
        bus.mst_awready = 1'b1;
        tick();
        bus.mst_awready = 1'b0;
        chk("wr_awvalid_drop", bus.mst_awvalid, 0);
        chk("wr_wvalid_hold1", bus.mst_wvalid, 1);
        tick();
        chk("wr_wvalid_hold2", bus.mst_wvalid, 1);
        chk("wr_no_b_yet", bus.lsu_b_valid, 0);
        bus.mst_wready = 1'b1;
        tick();
        bus.mst_wready = 1'b0;
        chk("wr_wvalid_drop", bus.mst_wvalid, 0);
        bus.mst_bvalid = 1'b1; bus.mst_bresp = 2'b00; bus.mst_bid = 4'd1;
        #1;
        chk("wr_b_valid", bus.lsu_b_valid, 1);
        chk("wr_b_resp", bus.lsu_b_resp, 2'b00);
        chk("wr_bready", bus.mst_bready, 1);
        tick();
        bus.mst_bvalid = 1'b0;
        chk("wr_b_done", bus.lsu_b_valid, 0);

        // Queued LSU load, with the LSU refusing the response for five cycles.
        chk("bp_ar_ready", bus.lsu_ar_ready, 1);
        tick();
        bus.lsu_ar_valid = 1'b0;
        ar_phase("bp", 4'd1, 32'h8000_0300, 3'b010);
        bus.lsu_r_ready = 1'b0;
        bus.mst_rvalid = 1'b1; bus.mst_rdata = 32'hCAFE_F00D; bus.mst_rid = 4'd1;
        bus.mst_rresp = 2'b00; bus.mst_rlast = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rready_low", bus.mst_rready, 0);
            chk("bp_rvalid_seen", bus.lsu_r_valid, 1);
            tick();
        end
        bus.lsu_r_ready = 1'b1;
        #1;
        chk("bp_rready_rise", bus.mst_rready, 1);
        chk("bp_rdata", bus.lsu_r_data, 32'hCAFE_F00D);
        tick();
        bus.mst_rvalid = 1'b0;
        bus.mst_rlast  = 1'b0;
        chk("bp_idle_no_rvalid", bus.lsu_r_valid, 0);

        // IFU fetch whose slave stays silent.
        bus.ifu_ar_valid = 1'b1; bus.ifu_ar_addr = 32'h8000_0010;
        #1;
        chk("silent_ar_ready", bus.ifu_ar_ready, 1);
        tick();
        bus.ifu_ar_valid = 1'b0;
        ar_phase("silent", 4'd0, 32'h8000_0010, 3'b010);
`ifdef YSYX_23060251_ARB_TIMEOUT_EN
        repeat (254) tick();
        chk("to_before_limit", bus.ifu_r_valid, 0);
        tick();
        chk("to_rvalid", bus.ifu_r_valid, 1);
        chk("to_resp", bus.ifu_r_resp, 2'b10);
        chk("to_data", bus.ifu_r_data, 32'h0);
        chk("to_rready", bus.mst_rready, 0);
        bus.ifu_ar_valid = 1'b1; bus.ifu_ar_addr = 32'h8000_0014;
        tick();
        chk("drain_no_grant", bus.ifu_ar_ready, 0);
        chk("drain_rready", bus.mst_rready, 1);
        bus.mst_rvalid = 1'b1; bus.mst_rdata = 32'h1111_2222; bus.mst_rid = 4'd0; bus.mst_rlast = 1'b1;
        #1;
        chk("drain_swallow", bus.ifu_r_valid, 0);
        tick();
        bus.mst_rvalid = 1'b0;
        bus.mst_rlast  = 1'b0;
`else
        repeat (300) tick();
        chk("silent_no_rvalid", bus.ifu_r_valid, 0);
        chk("silent_rready", bus.mst_rready, 1);
        r_phase("late", 1'b0, 4'd0, 32'h5555_AAAA);
`endif

        // Next fetch reaches RD_R, then reset abandons it.
        bus.ifu_ar_valid = 1'b1; bus.ifu_ar_addr = 32'h8000_0014;
        #1;
        chk("pre_rst_ar_ready", bus.ifu_ar_ready, 1);
        tick();
        bus.ifu_ar_valid = 1'b0;
        ar_phase("pre_rst", 4'd0, 32'h8000_0014, 3'b010);
        chk("no_rid_err", bus.dbg_rid_err, 0);
        rst_n = 1'b0;
        bus.ifu_ar_valid = 1'b1; bus.ifu_ar_addr = 32'h8000_0018;
        bus.lsu_ar_valid = 1'b1; bus.lsu_ar_addr = 32'h8000_0400; bus.lsu_ar_size = 3'b010;
        tick();
        chk("mid_rst_rready", bus.mst_rready, 0);
        chk("mid_rst_ifu_rvalid", bus.ifu_r_valid, 0);
        chk("mid_rst_arvalid", bus.mst_arvalid, 0);
        chk("mid_rst_ar_ready", bus.ifu_ar_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ifu_first", bus.ifu_ar_ready, 1);
        chk("post_rst_lsu_wait", bus.lsu_ar_ready, 0);
        tick();
        bus.ifu_ar_valid = 1'b0;
        bus.lsu_ar_valid = 1'b0;
        chk("post_rst_arid", bus.mst_arid, 4'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
